// File: rtl/mips_pkg.sv
// Shared constants and types for the multi-cycle MIPS control sequencer.
// OP_HALT only decodes as HALT when UC_HALT_EN is defined.
package mips_pkg;

  localparam int CONT_W = 4;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic [3:0] {
    CL_R, CL_JR, CL_LW, CL_SW, CL_BEQ, CL_J, CL_ADDI, CL_ILL, CL_HALT
  } inst_class_t;

  typedef enum logic [3:0] {
    ST_FETCH = 4'd0, ST_IR = 4'd1, ST_DEC = 4'd2, ST_EX1 = 4'd3, ST_EX2 = 4'd4,
    ST_S5 = 4'd5, ST_S6 = 4'd6, ST_S7 = 4'd7, ST_S8 = 4'd8, ST_S9 = 4'd9,
    ST_S10 = 4'd10
  } step_t;

  localparam logic [3:0] LAST_R    = 4'd8;
  localparam logic [3:0] LAST_ADDI = 4'd8;
  localparam logic [3:0] LAST_LW   = 4'd10;
  localparam logic [3:0] LAST_SW   = 4'd9;
  localparam logic [3:0] LAST_BEQ  = 4'd6;
  localparam logic [3:0] LAST_J    = 4'd5;
  localparam logic [3:0] LAST_JR   = 4'd5;
  localparam logic [3:0] LAST_ILL  = 4'd5;
  localparam logic [3:0] LAST_HALT = 4'd2;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/decodificador_opcode.sv
// Combinational opcode/funct decoder: instruction class, last step and the
// execute-phase datapath controls. HALT decode exists only with UC_HALT_EN.
module decodificador_opcode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] cls,
  output logic [3:0] last,
  output logic       alusrc,
  output logic       regdst,
  output logic [1:0] aluop,
  output logic       memtoreg
);

  // map opcode to class and its execute controls; unknown opcodes run as NOP
  always_comb begin
    cls      = CL_ILL;
    last     = LAST_ILL;
    alusrc   = 1'b0;
    regdst   = 1'b0;
    aluop    = ALU_ADD;
    memtoreg = 1'b0;
    case (opcode)
      OP_R: begin
        regdst = 1'b1;
        aluop  = ALU_FUNCT;
        if (funct == FUNCT_JR) begin
          cls  = CL_JR;
          last = LAST_JR;
        end else begin
          cls  = CL_R;
          last = LAST_R;
        end
      end
      OP_LW: begin
        cls      = CL_LW;
        last     = LAST_LW;
        alusrc   = 1'b1;
        memtoreg = 1'b1;
      end
      OP_SW: begin
        cls    = CL_SW;
        last   = LAST_SW;
        alusrc = 1'b1;
      end
      OP_BEQ: begin
        cls   = CL_BEQ;
        last  = LAST_BEQ;
        aluop = ALU_SUB;
      end
      OP_J: begin
        cls  = CL_J;
        last = LAST_J;
      end
      OP_ADDI: begin
        cls    = CL_ADDI;
        last   = LAST_ADDI;
        alusrc = 1'b1;
      end
`ifdef UC_HALT_EN
      OP_HALT: begin
        cls  = CL_HALT;
        last = LAST_HALT;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/unidade_controle_ciclos.sv
// Multi-cycle control sequencer: owns the step counter cont and drives
// registered per-step strobes. Define UC_HALT_EN to add HALT (0x3F) and the
// halted output.
module unidade_controle_ciclos
  import mips_pkg::*;
#(
  parameter int unsigned FETCH_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  output logic [CONT_W-1:0] cont,
  output logic              irwrite,
  output logic              memread,
  output logic              memwrite,
  output logic              memtoreg,
  output logic              regdst,
  output logic              alusrc,
  output logic [1:0]        aluop,
  output logic              regwrite,
  output logic              branch,
  output logic              jump,
  output logic              pcwrite,
`ifdef UC_HALT_EN
  output logic              halted,
`endif
  output logic              busy
);

  localparam logic [1:0] FW = FETCH_WAIT[1:0];

  step_t       state_q, state_d;
  logic [1:0]  wait_q, wait_d;
  inst_class_t cls_q, cls_d;
  logic [3:0]  last_q, last_d;
  logic        halt_q, halt_d;

  logic [3:0]  dec_cls_raw;
  inst_class_t dec_cls;
  logic [3:0]  dec_last;
  logic        dec_alusrc, dec_regdst, dec_memtoreg;
  logic [1:0]  dec_aluop;

  logic        irwrite_d, memread_d, memwrite_d, memtoreg_d, regdst_d, alusrc_d;
  logic [1:0]  aluop_d;
  logic        regwrite_d, branch_d, jump_d, pcwrite_d, busy_d, ending;

  decodificador_opcode u_dec (
    .opcode   (opcode),
    .funct    (funct),
    .cls      (dec_cls_raw),
    .last     (dec_last),
    .alusrc   (dec_alusrc),
    .regdst   (dec_regdst),
    .aluop    (dec_aluop),
    .memtoreg (dec_memtoreg)
  );

  assign dec_cls = inst_class_t'(dec_cls_raw);
  assign cont    = state_q;
`ifdef UC_HALT_EN
  assign halted  = halt_q;
`endif

  // next step, wait counter, latched class, and the strobes of the step entered next
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cls_d   = cls_q;
    last_d  = last_q;
    halt_d  = halt_q;
    case (state_q)
      ST_FETCH: begin
        if (wait_q == FW) begin
          state_d = ST_IR;
          wait_d  = 2'd0;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      ST_IR: state_d = ST_DEC;
      ST_DEC: begin
        if (halt_q || dec_cls == CL_HALT) begin
          halt_d = 1'b1;
        end else begin
          cls_d   = dec_cls;
          last_d  = dec_last;
          state_d = ST_EX1;
        end
      end
      default: begin
        if (state_q == last_q || state_q >= ST_S10) state_d = ST_FETCH;
        else state_d = step_t'(state_q + 4'd1);
      end
    endcase

    ending     = (state_d >= ST_EX1) && (state_d == last_d);
    irwrite_d  = (state_d == ST_IR);
    memread_d  = (state_d == ST_FETCH) ||
                 (cls_d == CL_LW && state_d >= ST_S6 && state_d <= ST_S9);
    memwrite_d = (state_d == ST_S6) && (cls_d == CL_SW);
    branch_d   = (state_d == ST_S5) && (cls_d == CL_BEQ);
    jump_d     = (state_d == ST_S5) && (cls_d == CL_J || cls_d == CL_JR);
    pcwrite_d  = ending;
    regwrite_d = ending && (cls_d == CL_R || cls_d == CL_ADDI || cls_d == CL_LW);
    busy_d     = (state_d != ST_FETCH);

    // execute controls load on entering step 3; memtoreg then holds across the next fetch
    memtoreg_d = memtoreg;
    alusrc_d   = alusrc;
    regdst_d   = regdst;
    aluop_d    = aluop;
    if (state_q == ST_DEC && state_d == ST_EX1) begin
      memtoreg_d = dec_memtoreg;
      alusrc_d   = dec_alusrc;
      regdst_d   = dec_regdst;
      aluop_d    = dec_aluop;
    end else if (state_d == ST_FETCH) begin
      alusrc_d = 1'b0;
      regdst_d = 1'b0;
      aluop_d  = ALU_ADD;
    end
  end

  // state and registered outputs; reset abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      wait_q   <= 2'd0;
      cls_q    <= CL_ILL;
      last_q   <= LAST_ILL;
      halt_q   <= 1'b0;
      irwrite  <= 1'b0;
      memread  <= 1'b0;
      memwrite <= 1'b0;
      memtoreg <= 1'b0;
      regdst   <= 1'b0;
      alusrc   <= 1'b0;
      aluop    <= ALU_ADD;
      regwrite <= 1'b0;
      branch   <= 1'b0;
      jump     <= 1'b0;
      pcwrite  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      cls_q    <= cls_d;
      last_q   <= last_d;
      halt_q   <= halt_d;
      irwrite  <= irwrite_d;
      memread  <= memread_d;
      memwrite <= memwrite_d;
      memtoreg <= memtoreg_d;
      regdst   <= regdst_d;
      alusrc   <= alusrc_d;
      aluop    <= aluop_d;
      regwrite <= regwrite_d;
      branch   <= branch_d;
      jump     <= jump_d;
      pcwrite  <= pcwrite_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_unidade_controle_ciclos.sv
// Scoreboard bench for unidade_controle_ciclos (FETCH_WAIT=0). Halt checks
// are compiled in when UC_HALT_EN is defined.
module tb_unidade_controle_ciclos;

  typedef struct packed {
    logic [3:0] cont;
    logic       irwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       alusrc;
    logic [1:0] aluop;
    logic       regwrite;
    logic       branch;
    logic       jump;
    logic       pcwrite;
    logic       busy;
    logic       halted;
  } vec_t;

  typedef struct {
    string name;
    vec_t  v;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic [3:0] cont;
  logic       irwrite, memread, memwrite, memtoreg, regdst, alusrc;
  logic [1:0] aluop;
  logic       regwrite, branch, jump, pcwrite, busy;
  logic       halted_w;

  item_t q[$];
  int    n_pass = 0;
  int    n_total = 0;
  logic  m_mtr = 1'b0;

  unidade_controle_ciclos #(.FETCH_WAIT(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .funct    (funct),
    .cont     (cont),
    .irwrite  (irwrite),
    .memread  (memread),
    .memwrite (memwrite),
    .memtoreg (memtoreg),
    .regdst   (regdst),
    .alusrc   (alusrc),
    .aluop    (aluop),
    .regwrite (regwrite),
    .branch   (branch),
    .jump     (jump),
    .pcwrite  (pcwrite),
`ifdef UC_HALT_EN
    .halted   (halted_w),
`endif
    .busy     (busy)
  );

`ifndef UC_HALT_EN
  assign halted_w = 1'b0;
`endif

  always #5 clk = ~clk;

  // expected outputs after entering step n for the given instruction
  function automatic vec_t model(int n, logic [5:0] op, logic [5:0] fn, logic mtr_prev);
    vec_t v;
    logic r, jr, lw, sw, beq, j, addi;
    int   last;
    v    = '0;
    r    = (op == 6'h00) && (fn != 6'h08);
    jr   = (op == 6'h00) && (fn == 6'h08);
    lw   = (op == 6'h23);
    sw   = (op == 6'h2B);
    beq  = (op == 6'h04);
    j    = (op == 6'h02);
    addi = (op == 6'h08);
    last = (r || addi) ? 8 : lw ? 10 : sw ? 9 : beq ? 6 : 5;
    v.cont     = n[3:0];
    v.busy     = (n != 0);
    v.irwrite  = (n == 1);
    v.memread  = (n == 0) || (lw && n >= 6 && n <= 9);
    v.memtoreg = (n >= 3) ? lw : mtr_prev;
    if (n >= 3) begin
      v.alusrc = lw || sw || addi;
      v.regdst = r || jr;
      v.aluop  = (r || jr) ? 2'b10 : beq ? 2'b01 : 2'b00;
    end
    v.branch   = (n == 5) && beq;
    v.jump     = (n == 5) && (j || jr);
    v.memwrite = (n == 6) && sw;
    v.pcwrite  = (n == last) && (n != 0);
    v.regwrite = (n == last) && (r || addi || lw);
    return v;
  endfunction

  task automatic push(string name, vec_t v);
    item_t it;
    it.name = name;
    it.v    = v;
    q.push_back(it);
  endtask

  task automatic reset_cycles(int k);
    rst_n = 1'b0;
    m_mtr = 1'b0;
    for (int i = 0; i < k; i++) begin
      push("reset", vec_t'(0));
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  task automatic run_steps(string name, logic [5:0] op, logic [5:0] fn, int upto, bit wrap);
    vec_t v;
    int   n;
    opcode = op;
    funct  = fn;
    for (int i = 1; i <= upto; i++) begin
      n = (wrap && i == upto) ? 0 : i;
      v = model(n, op, fn, m_mtr);
      m_mtr = v.memtoreg;
      push(name, v);
      @(negedge clk);
    end
  endtask

  // full instruction: ncyc = LAST+1 edges, ending back at step 0
  task automatic run_instr(string name, logic [5:0] op, logic [5:0] fn, int ncyc);
    run_steps(name, op, fn, ncyc, 1'b1);
  endtask

  // monitor: one output vector per clock, compared against the oldest expectation
  initial begin
    item_t it;
    vec_t  got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        it  = q.pop_front();
        got = '{cont, irwrite, memread, memwrite, memtoreg, regdst, alusrc, aluop,
                regwrite, branch, jump, pcwrite, busy, halted_w};
        n_total++;
        if (got === it.v) n_pass++;
        else $display("FAIL %s: got=%h expected=%h (cont got %0d expected %0d)",
                      it.name, got, it.v, got.cont, it.v.cont);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hv;
    @(negedge clk);
    reset_cycles(2);
    run_instr("r_add", 6'h00, 6'h20, 9);
    run_instr("lw", 6'h23, 6'h00, 11);
    run_instr("sw", 6'h2B, 6'h00, 10);
    run_instr("beq", 6'h04, 6'h00, 7);
    run_instr("j", 6'h02, 6'h00, 6);
    run_instr("illegal", 6'h11, 6'h00, 6);
    run_instr("jr", 6'h00, 6'h08, 6);
    run_instr("addi", 6'h08, 6'h00, 9);
    run_instr("lw_hold", 6'h23, 6'h00, 11);
    run_instr("addi_mtr", 6'h08, 6'h00, 9);
    run_steps("lw_abort", 6'h23, 6'h00, 8, 1'b0);
    reset_cycles(1);
    run_instr("addi_after", 6'h08, 6'h00, 9);
`ifdef UC_HALT_EN
    run_steps("halt_entry", 6'h3F, 6'h00, 2, 1'b0);
    for (int i = 0; i < 100; i++) begin
      hv        = model(2, 6'h3F, 6'h00, m_mtr);
      hv.halted = 1'b1;
      push("halt_hold", hv);
      @(negedge clk);
    end
    reset_cycles(1);
    run_instr("addi_post_halt", 6'h08, 6'h00, 9);
`else
    run_instr("op3f_nop", 6'h3F, 6'h00, 6);
`endif
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: pending=%0d required=0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/unidade_controle_ciclos.md
Name: unidade_controle_ciclos

Overview:
- Multi-cycle control sequencer for the MIPS simulator datapath.
- Owns the 4-bit step counter `cont`, which every datapath stage samples to decide when to act.
- Decodes the latched opcode and drives per-step control strobes, including `memtoreg`, which the write-back selector consumes: ALU result at `cont==7`, load data at `cont==9`.
- Sits upstream of the write-back selector and the register bank; PC update happens at the end of every instruction.

Parameters:
- CONT_W, 4, counter width; fixed; max reachable value 10.
- FETCH_WAIT, 1, extra cycles spent at `cont==0` waiting on instruction memory (0..3).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  instruction[31:26], valid from `cont==2` onward
- funct  in  6  instruction[5:0], used only for R-type jr detection
- cont  out  4  current step number
- irwrite  out  1  latch instruction register (pulse)
- memread  out  1  data/instruction memory read enable
- memwrite  out  1  data memory write enable (pulse)
- memtoreg  out  1  1 = write-back selects load data
- regdst  out  1  1 = rd destination, 0 = rt
- alusrc  out  1  1 = immediate operand
- aluop  out  2  00 add, 01 sub (beq), 10 R-type funct
- regwrite  out  1  register bank write strobe (pulse)
- branch  out  1  beq compare window
- jump  out  1  j target select
- pcwrite  out  1  PC update strobe (pulse)
- busy  out  1  high while an instruction is mid-sequence (`cont!=0`)

Behaviour:
- Reset (`rst_n` low at posedge):
  - `cont`=0, all strobes 0, `aluop`=00, `busy`=0, wait counter cleared.
  - Reset mid-instruction abandons it: no `pcwrite` and no `regwrite` are issued.
- Instruction classes (from the opcode latched at `cont==2`):
  - R = 0x00
  - LW = 0x23
  - SW = 0x2B
  - BEQ = 0x04
  - J = 0x02
  - ADDI = 0x08
  - Any other opcode is ILLEGAL.
- Step schedule (all outputs registered, changing on the posedge that enters the step):
  - 0: `memread`=1. Hold for FETCH_WAIT extra cycles using an internal wait counter.
  - 1: `irwrite`=1 for exactly one cycle.
  - 2: decode; opcode/funct sampled into an internal class register.
  - 3–4: execute. `alusrc`=1 for LW/SW/ADDI; `aluop` per class; `regdst`=1 for R only.
  - 5:
    - J: `jump`=1, then LAST.
    - BEQ: `branch`=1.
    - Others: continue.
  - 6:
    - BEQ: LAST.
    - SW: `memwrite` pulse.
    - LW: `memread`=1.
  - 7: `memtoreg` steady from step 3 onward (1 for LW, 0 otherwise). The ALU write-back value is captured downstream here.
  - 8:
    - R/ADDI: `regwrite` pulse, then LAST.
    - LW: `memread` continues.
  - 9:
    - SW: LAST.
    - LW: load data captured downstream.
  - 10: LW: `regwrite` pulse, then LAST.
- LAST step:
  - R/ADDI = 8, LW = 10, SW = 9, BEQ = 6, J = 5.
  - At LAST, `pcwrite`=1 for one cycle; the next edge sets `cont`=0.
- `cont` never exceeds 10.
- `regwrite` is never asserted for SW, BEQ, J or ILLEGAL.
- `memtoreg` holds its value until step 3 of the next instruction.
- ILLEGAL opcode: treated as a NOP with LAST=5. `pcwrite` only.
- jr (R, funct 0x08): LAST=5, `jump`=1 at step 5, no `regwrite`.

Optional Feature:
- Macro: UC_HALT_EN.
- When defined:
  - Opcode 0x3F decodes as HALT.
  - At step 2 the sequencer freezes: `cont` stays 2 and all strobes stay 0 until reset.
  - Adds output `halted` (1 bit, reset 0), set on entry to the halt.
- When undefined:
  - 0x3F is ILLEGAL (NOP path).
  - No `halted` port.

Decomposition:
- Shared package `mips_pkg`:
  - opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_HALT)
  - FUNCT_JR
  - instruction-class enum
  - LAST-step constants per class
  - aluop encodings
- Natural sub-module: `decodificador_opcode`, a combinational block mapping opcode/funct to class, last step, `alusrc`, `regdst`, `aluop` and `memtoreg`.

Test Plan:
- `rst_n`=0 for 2 cycles, then 1, FETCH_WAIT=0, opcode=0x00 → `cont` walks 0..8; `irwrite` at 1; `regwrite` and `pcwrite` high at cont 8 only; `memtoreg`=0 at cont 7.
- LW (0x23) → `memtoreg`=1 from cont 3; `regwrite` at cont 10; `pcwrite` at 10; `cont` returns to 0; 11 cycles total.
- SW (0x2B) then BEQ (0x04) back-to-back → `memwrite` pulse at cont 6, LAST 9; BEQ: `branch` at 5, `pcwrite` at 6; `regwrite` never high.
- J (0x02) and opcode 0x11 (ILLEGAL) → both end at cont 5 with `pcwrite`; `jump`=1 only for J.
- LW with `rst_n` dropped at cont 8 → next cycle `cont`=0, all strobes 0, no `regwrite`/`pcwrite`; a following ADDI completes normally.
- UC_HALT_EN defined, opcode 0x3F → `cont` sticks at 2, `halted`=1 after 100 cycles; reset clears it.
